// File: rtl/alu_pkg.sv
// Shared types for the lane-serial ALU: opcode and FSM state encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_EOR = 4'd3,
        OP_OR  = 4'd4,
        OP_LSR = 4'd5,
        OP_ASL = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Codes from here to 15 produce a zero result and clear carry.
    localparam logic [3:0] OP_RSVD_MIN = 4'd9;

endpackage

// File: rtl/alu_lane.sv
// Combinational LANE_W-bit ALU slice; BCD adjust is built only with DECIMAL_MODE_EN.
module alu_lane
    import alu_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  alu_op_t           op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    input  logic              dec,
    output logic [LANE_W-1:0] res,
    output logic              cout
);

    logic [LANE_W-1:0] b_eff;
    logic [LANE_W:0]   sum;
    logic              rsvd;

    assign rsvd  = (4'(op) >= OP_RSVD_MIN);
    assign b_eff = (op == OP_SUB) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{LANE_W{1'b0}}, cin};

`ifdef DECIMAL_MODE_EN
    // Nibble-serial BCD add/subtract; the carry ripples nibble to nibble.
    function automatic logic [LANE_W:0] bcd_addsub(input logic [LANE_W-1:0] x,
                                                   input logic [LANE_W-1:0] y,
                                                   input logic c,
                                                   input logic sub);
        logic [4:0]        nib;
        logic              carry;
        logic [LANE_W-1:0] r;
        carry = c;
        r     = '0;
        for (int i = 0; i < LANE_W / 4; i++) begin
            nib = {1'b0, x[4*i +: 4]} + {1'b0, (sub ? ~y[4*i +: 4] : y[4*i +: 4])} + {4'd0, carry};
            if (sub) begin
                carry = nib[4];
                if (!nib[4]) nib = nib - 5'd6;
            end else if (nib > 5'd9) begin
                nib   = nib + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            r[4*i +: 4] = nib[3:0];
        end
        return {carry, r};
    endfunction
`else
    logic unused_dec;
    assign unused_dec = dec;
`endif

    always_comb begin
        res  = '0;
        cout = 1'b0;
        if (!rsvd) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    {cout, res} = sum;
`ifdef DECIMAL_MODE_EN
                    if (dec) {cout, res} = bcd_addsub(a, b, cin, op == OP_SUB);
`endif
                end
                OP_AND: res = a & b;
                OP_EOR: res = a ^ b;
                OP_OR:  res = a | b;
                OP_LSR, OP_ROR: begin
                    res  = {cin, a[LANE_W-1:1]};
                    cout = a[0];
                end
                OP_ASL, OP_ROL: begin
                    res  = {a[LANE_W-2:0], cin};
                    cout = a[LANE_W-1];
                end
                default: begin
                    res  = '0;
                    cout = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Lane-serial ALU top: FSM, lane sequencing, shadow accumulation and flag commit.
// Optional BCD arithmetic is enabled by defining DECIMAL_MODE_EN.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             dec,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);

    localparam int LANES = WIDTH / LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    alu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  lane_sel;
    logic [WIDTH-1:0]  a_q, b_q, shadow_q, shadow_next;
    alu_op_t           op_q;
    logic              carry_q;
    logic              dec_lane;
    logic              accept, last_lane, msb_first;
    logic [LANE_W-1:0] lane_a, lane_b, lane_res;
    logic              lane_cout;
    logic              b_msb, ovf_next;

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign accept    = start && (state_q != RUN);
    assign last_lane = (cnt_q == LAST);
    assign msb_first = (op_q == OP_LSR) || (op_q == OP_ROR);
    assign lane_sel  = msb_first ? (LAST - cnt_q) : cnt_q;
    assign lane_a    = a_q[int'(lane_sel) * LANE_W +: LANE_W];
    assign lane_b    = b_q[int'(lane_sel) * LANE_W +: LANE_W];

`ifdef DECIMAL_MODE_EN
    logic dec_q;
    assign dec_lane = dec_q;
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign dec_lane   = 1'b0;
`endif

    alu_lane #(.LANE_W(LANE_W)) u_lane (
        .op   (op_q),
        .a    (lane_a),
        .b    (lane_b),
        .cin  (carry_q),
        .dec  (dec_lane),
        .res  (lane_res),
        .cout (lane_cout)
    );

    always_comb begin
        shadow_next = shadow_q;
        shadow_next[int'(lane_sel) * LANE_W +: LANE_W] = lane_res;
    end

    // Overflow is judged on the effective second operand, so SUB uses ~b.
    assign b_msb    = (op_q == OP_SUB) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
    assign ovf_next = ((op_q == OP_ADD) || (op_q == OP_SUB))
                      && (a_q[WIDTH-1] == b_msb)
                      && (shadow_next[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_lane) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            neg     <= 1'b0;
            zero    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((state_q == RUN) && last_lane) begin
                res  <= shadow_next;
                cout <= lane_cout;
                ovf  <= ovf_next;
                neg  <= shadow_next[WIDTH-1];
                zero <= (shadow_next == '0);
            end
        end
    end

    // Operand and shadow storage carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= ((op == OP_LSR) || (op == OP_ASL)) ? 1'b0 : cin;
`ifdef DECIMAL_MODE_EN
            dec_q   <= dec;
`endif
        end else if (state_q == RUN) begin
            shadow_q <= shadow_next;
            carry_q  <= lane_cout;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=16, LANE_W=8.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic        c, v, n, z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, cin, dec;
    alu_op_t     op;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf, neg, zero;
    logic [15:0] res;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_seq #(.WIDTH(16), .LANE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cin(cin), .dec(dec), .busy(busy), .done(done), .res(res),
        .cout(cout), .ovf(ovf), .neg(neg), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] code, input logic [15:0] x,
                                   input logic [15:0] y, input logic ci, input logic dm);
        exp_t        e;
        logic [16:0] w;
        logic [15:0] yi;
        int          c, s;
        e  = '0;
        yi = (code == 4'd1) ? ~y : y;
        case (code)
            4'd0, 4'd1: begin
                w = {1'b0, x} + {1'b0, yi} + 17'(ci);
                e.res = w[15:0];
                e.c   = w[16];
`ifdef DECIMAL_MODE_EN
                if (dm) begin
                    c = int'(ci);
                    for (int i = 0; i < 4; i++) begin
                        if (code == 4'd0) begin
                            s = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
                            if (s > 9) begin s = s - 10; c = 1; end else c = 0;
                        end else begin
                            s = int'(x[4*i +: 4]) - int'(y[4*i +: 4]) - (1 - c);
                            if (s < 0) begin s = s + 10; c = 0; end else c = 1;
                        end
                        e.res[4*i +: 4] = 4'(s);
                    end
                    e.c = c[0];
                end
`else
                c = int'(dm);
                s = c;
`endif
                e.v = (x[15] == yi[15]) && (e.res[15] != x[15]);
            end
            4'd2: e.res = x & y;
            4'd3: e.res = x ^ y;
            4'd4: e.res = x | y;
            4'd5: begin e.res = {1'b0, x[15:1]}; e.c = x[0];  end
            4'd6: begin e.res = {x[14:0], 1'b0}; e.c = x[15]; end
            4'd7: begin e.res = {x[14:0], ci};   e.c = x[15]; end
            4'd8: begin e.res = {ci, x[15:1]};   e.c = x[0];  end
            default: e.res = 16'h0000;
        endcase
        e.n = e.res[15];
        e.z = (e.res == 16'h0000);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_res"},  32'(res),  32'(e.res));
            chk({tag, "_c"},    32'(cout), 32'(e.c));
            chk({tag, "_v"},    32'(ovf),  32'(e.v));
            chk({tag, "_n"},    32'(neg),  32'(e.n));
            chk({tag, "_z"},    32'(zero), 32'(e.z));
        end
    endtask

    task automatic drive(input logic [3:0] code, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic dm);
        op    = alu_op_t'(code);
        a     = x;
        b     = y;
        cin   = ci;
        dec   = dm;
        start = 1'b1;
        sb.push_back(model(code, x, y, ci, dm));
    endtask

    // Issues one operation, waits for done at negedges and checks latency and result.
    task automatic run_op(input string tag, input logic [3:0] code, input logic [15:0] x,
                          input logic [15:0] y, input logic ci, input logic dm);
        int lat;
        int busy_n;
        @(negedge clk);
        drive(code, x, y, ci, dm);
        @(negedge clk);
        start  = 1'b0;
        a      = 16'hDEAD;
        b      = 16'hBEEF;
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd2);
        check_result(tag);
    endtask

    initial begin
        logic saw_done;
        logic [15:0] dec_exp;
        rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0; cin = 1'b0; dec = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res",  32'(res),  32'h0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", {29'd0, cout, ovf, neg}, 32'd0);
        rst = 1'b0;

        run_op("add_carry", 4'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_op("sub_ovf",   4'd1, 16'h8000, 16'h0001, 1'b1, 1'b0);
        run_op("asl",       4'd6, 16'h8001, 16'h0000, 1'b0, 1'b0);
        run_op("ror",       4'd8, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("lsr",       4'd5, 16'h0301, 16'h0000, 1'b1, 1'b0);
        run_op("rol",       4'd7, 16'h4080, 16'h0000, 1'b1, 1'b0);
        run_op("add_wrap",  4'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op("eor",       4'd3, 16'hA5F0, 16'hFF0F, 1'b1, 1'b0);
        run_op("and",       4'd2, 16'hA5F0, 16'h0FF0, 1'b0, 1'b0);
        run_op("or",        4'd4, 16'h1200, 16'h0034, 1'b0, 1'b0);
        run_op("rsvd",      4'd9, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        run_op("add_pos_ovf", 4'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);

        // Start while busy is dropped; start during DONE is taken.
        @(negedge clk);
        drive(4'd0, 16'h0010, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        op = OP_SUB; a = 16'hFFFF; b = 16'h0001; cin = 1'b1; start = 1'b1;
        chk("ign_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        check_result("ign");
        drive(4'd0, 16'h0100, 16'h0200, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_nodone1", 32'(done), 32'd0);
        chk("b2b_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_nodone2", 32'(done), 32'd0);
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'd1);
        check_result("b2b");

        // Reset during the second RUN cycle aborts without committing.
        @(negedge clk);
        op = OP_ADD; a = 16'h1234; b = 16'h1111; cin = 1'b0; dec = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res",  32'(res),  32'h0);
        chk("abort_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        run_op("dec_add", 4'd0, 16'h0099, 16'h0001, 1'b0, 1'b1);
        run_op("dec_sub", 4'd1, 16'h0100, 16'h0001, 1'b1, 1'b1);
`ifdef DECIMAL_MODE_EN
        dec_exp = 16'h0099;
`else
        dec_exp = 16'h00FF;
`endif
        chk("dec_sub_direct", 32'(res), 32'(dec_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, lane-serial ALU that replaces the single-cycle 8-bit datapath ALU wherever operands wider than one byte are needed, e.g. 16-bit address arithmetic and multi-byte shifts. It processes a WIDTH-bit operation one LANE_W-bit lane per clock through a shared lane datapath, chains carry between lanes, and presents registered results and N/Z/C/V flags behind a start/busy/done handshake. The operation set matches the 6502 ALU: add/subtract with carry, AND, EOR, OR, LSR, ASL, ROL and ROR. Optional BCD arithmetic is available.

## Interface
- WIDTH, 16: operand width. Must be a multiple of LANE_W, range 8..64.
- LANE_W, 8: bits processed per cycle. Must be a multiple of 4.
- LANES is derived: WIDTH/LANE_W.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- start  in  1  request. Sampled only when busy=0.
- op  in  4  opcode, alu_pkg::alu_op_t.
- a, b  in  WIDTH  operands.
- cin  in  1  carry in. For SUB, 1 means no borrow.
- dec  in  1  decimal mode for ADD/SUB.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results updated this cycle.
- res  out  WIDTH  result.
- cout, ovf, neg, zero  out  1 each  flags C, V, N, Z.

## Operation
- Opcodes and behaviour:
  - ADD=0: res = a + b + cin.
  - SUB=1: res = a + ~b + cin.
  - AND=2, EOR=3, OR=4: bitwise; cout=0.
  - LSR=5: shift right by 1, 0 into the MSB, LSB goes to cout.
  - ASL=6: shift left by 1, 0 into the LSB, MSB goes to cout.
  - ROL=7: as ASL, but cin into the LSB.
  - ROR=8: as LSR, but cin into the MSB.
  - Codes 9–15 are reserved: res=0, cout=0, ovf=0, zero=1.
- FSM states IDLE, RUN, DONE.
  - IDLE→RUN on start: latch a, b, op, cin, dec; clear lane counter.
  - RUN processes one lane per cycle. After lane LANES-1 it goes to DONE.
  - DONE lasts one cycle, then IDLE. A start in DONE is accepted (DONE→RUN).
- Lane order:
  - LSR and ROR process lanes MSB lane first.
  - All other ops process lanes LSB lane first.
- Carry chaining: the lane carry-out feeds the next lane's carry-in. The first lane receives the latched cin, or 0 for LSR/ASL.
- Flags are computed on the final full-width result:
  - neg = res[WIDTH-1].
  - zero = (res == 0).
  - ovf applies to ADD/SUB only: (A.msb == Bint.msb) and (res.msb != A.msb), where Bint = ~b for SUB. For all other ops ovf = 0.
- Partial results accumulate in an internal shadow register. res and the flags change only on DONE entry and hold until the next DONE.
- A start while busy=1 is ignored; it is neither queued nor latched.
- Operand inputs may change freely after the start cycle.

## Timing
- Reset values: state IDLE; res=0; busy, done, cout, ovf and neg all 0; zero=1.
- Reset mid-RUN aborts the operation. Nothing is committed to res.
- Latency: start sampled at edge k; busy=1 for cycles k+1..k+LANES; done=1 in cycle k+LANES+1, with new res/flags visible in that same cycle.
- Throughput: back-to-back starts issued during DONE yield one result every LANES+1 cycles.
- When LANES=1: one RUN cycle, done at k+2.

## Configuration
- DECIMAL_MODE_EN defined: ADD/SUB with latched dec=1 operate on packed BCD.
  - Per nibble: ADD adds 6 when nibble sum > 9 or nibble carry; SUB subtracts 6 on nibble borrow.
  - The nibble carry chains across nibbles and lanes.
  - cout is the decimal carry. N, Z and V are taken from the adjusted result.
- DECIMAL_MODE_EN undefined: dec is ignored and all arithmetic is binary (2A03 behaviour). No BCD logic is synthesised.

## Structure
- Package alu_pkg holds:
  - alu_op_t, a 4-bit enum with the codes above;
  - the state enum {IDLE, RUN, DONE};
  - the reserved-code range constant.
- Sub-module alu_lane: combinational LANE_W-bit slice.
  - Inputs: op, operand lanes, carry in, dec.
  - Outputs: lane result, carry out.
  - BCD adjust is placed inside it under the macro.
- Top level owns the FSM, lane counter, operand/shadow registers, lane muxing and flag generation.

## Test plan
All scenarios use WIDTH=16, LANE_W=8.
- ADD a=0x00FF, b=0x0001, cin=0 → res=0x0100, C=0, V=0, Z=0, N=0. done exactly 3 cycles after the start edge; busy high for 2 cycles.
- SUB a=0x8000, b=0x0001, cin=1 → res=0x7FFF, C=1, V=1, N=0.
- ASL a=0x8001 → res=0x0002, C=1. Then ROR a=0x0001, cin=1 → res=0x8000, C=1, N=1.
- Second start pulsed while busy → ignored; only one done, carrying the first result. A start during DONE → second done 3 cycles later.
- Assert rst during the second RUN cycle of ADD 0x1234+0x1111 → immediately busy=0, res=0, zero=1. No done pulse follows.
- ADD dec=1, a=0x0099, b=0x0001, cin=0 → res=0x0100, C=0 with DECIMAL_MODE_EN; res=0x009A without it.
